fft_bin_streamer: RTL

Output-side companion to `fft_radix4_top`. It captures the 16-bin parallel result frame when the FFT signals completion and replays it as a serial stream, one complex bin per beat, over a valid/ready handshake. It optionally undoes base-4 digit reversal so bins leave in natural order. It sits between the FFT core and downstream consumers such as the magnitude unit or the host readout.

---
 rtl/fft_bin_streamer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fft_bin_streamer.sv
// Captures a 16-bin parallel FFT result frame and replays it one complex bin per
// valid/ready beat, optionally undoing base-4 digit reversal.
module fft_bin_streamer #(
  parameter int WIDTH     = 16,
  parameter int DIGIT_REV = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_fft_done,
  input  logic [WIDTH*16-1:0] i_fft_real_in,
  input  logic [WIDTH*16-1:0] i_fft_imag_in,
  output logic                o_m_valid,
  input  logic                i_m_ready,
  output logic [WIDTH-1:0]    o_m_real,
  output logic [WIDTH-1:0]    o_m_imag,
  output logic [3:0]          o_m_index,
  output logic                o_m_last,
  output logic                o_busy,
  output logic                o_overrun,
  input  logic                i_ovr_clr,
  output logic [7:0]          o_frame_count
);

  typedef enum logic {S_IDLE = 1'b0, S_STREAM = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_k;
  logic [3:0]       w_k_nxt;
  logic [3:0]       w_slot;
  logic             w_hs;
  logic             w_capture;
  logic             w_drop;
  logic             r_overrun;
  logic [7:0]       r_frame_count;
  logic [WIDTH-1:0] r_buf_re [16];
  logic [WIDTH-1:0] r_buf_im [16];

  assign w_hs   = o_m_valid & i_m_ready;
  // Digit reversal in base 4 is just swapping the two 2-bit halves of k.
  assign w_slot = (DIGIT_REV != 0) ? {r_k[1:0], r_k[3:2]} : r_k;

  assign o_m_valid     = (r_state == S_STREAM);
  assign o_busy        = (r_state == S_STREAM);
  assign o_m_index     = r_k;
  assign o_m_last      = o_m_valid & (r_k == 4'd15);
  assign o_m_real      = r_buf_re[w_slot];
  assign o_m_imag      = r_buf_im[w_slot];
  assign o_overrun     = r_overrun;
  assign o_frame_count = r_frame_count;

  // Next-state, beat counter and capture/drop decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_capture   = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_fft_done) begin
          w_state_nxt = S_STREAM;
          w_k_nxt     = 4'd0;
          w_capture   = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_STREAM: begin
        if (w_hs && (r_k == 4'd15)) begin
          w_k_nxt = 4'd0;
          // A capture landing on the final beat chains straight into the next frame.
          if (i_fft_done) begin
            w_capture = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (w_hs) begin
          w_k_nxt = r_k + 4'd1;
          w_drop  = i_fft_done;
        end else begin
          w_drop = i_fft_done;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_k_nxt     = 4'd0;
      end
    endcase
  end

  // State, counter, overrun flag and frame counter.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_k           <= 4'd0;
      r_overrun     <= 1'b0;
      r_frame_count <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (i_ovr_clr) begin
        r_overrun <= 1'b0;
      end
      if (w_capture) begin
        r_frame_count <= r_frame_count + 8'd1;
      end
    end
  end

  // Frame buffers, loaded only on an accepted capture.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int s = 0; s < 16; s++) begin
        r_buf_re[s] <= '0;
        r_buf_im[s] <= '0;
      end
    end else if (w_capture) begin
      for (int s = 0; s < 16; s++) begin
        r_buf_re[s] <= i_fft_real_in[WIDTH*s +: WIDTH];
        r_buf_im[s] <= i_fft_imag_in[WIDTH*s +: WIDTH];
      end
    end
  end

endmodule
